// File: rtl/serial_deserializer.sv
// Serial-to-parallel word assembler with a double-buffered holding register.
// A word is assembled in the shift register while the previous one waits in o_data for the consumer.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_d,
  input  logic                     i_d_valid,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_data_valid,
  input  logic                     i_data_ready,
  output logic [$clog2(WIDTH)-1:0] o_bit_count,
  output logic                     o_overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // state   | meaning
  // S_EMPTY | holding register has no unconsumed word
  // S_FULL  | holding register presents a word awaiting accept
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_shift;
  logic [CW-1:0]     r_bit_count;
  logic [WIDTH-1:0]  r_data;
  logic              r_data_valid;
  logic              r_overrun;

  logic [WIDTH-1:0]  w_shift_next;
  logic              w_complete;

  always_comb begin
    w_shift_next = r_shift;
    if (MSB_FIRST) begin
      w_shift_next = {r_shift[WIDTH-2:0], i_d};
    end else begin
      w_shift_next = {i_d, r_shift[WIDTH-1:1]};
    end
  end

  // Explicit wrap keeps the counter correct for non-power-of-two widths.
  assign w_complete = i_d_valid && (r_bit_count == LAST_BIT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_EMPTY;
      r_shift      <= '0;
      r_bit_count  <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (i_d_valid) begin
        r_shift     <= w_shift_next;
        r_bit_count <= w_complete ? '0 : r_bit_count + CW'(1);
      end

      case (r_state)
        S_EMPTY: begin
          if (w_complete) begin
            r_data       <= w_shift_next;
            r_data_valid <= 1'b1;
            r_state      <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_complete) begin
            // Accept and refill on the same edge; otherwise the new word is lost.
            if (i_data_ready) begin
              r_data <= w_shift_next;
            end else begin
              r_overrun <= 1'b1;
            end
          end else if (i_data_ready) begin
            r_data_valid <= 1'b0;
            r_state      <= S_EMPTY;
          end
        end
        default: begin
          r_data_valid <= 1'b0;
          r_state      <= S_EMPTY;
        end
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_bit_count  = r_bit_count;
  assign o_overrun    = r_overrun;

endmodule
